xor_frame_parity: RTL and testbench
===================================

Name: xor_frame_parity

Overview:
- Streaming parity generator built on XOR reduction, generalised from single-bit XOR to WIDTH-bit words and multi-word frames.
- Accumulates the column parity (bitwise XOR of all words) over a frame delimited by in_last. Emits column parity, row parity (even or odd mode) and beat count through a valid/ready output register.
- Sits between a word source and a checker or packetiser; used for frame integrity tags.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- ODD, 0, parity mode: 0 = even (out_row = XOR of all bits), 1 = odd (out_row inverted).
- COUNT_W, 16, width of the beat counter and out_count (>=2).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of current frame.
- out_valid  output  1  result registers hold an unconsumed frame result.
- out_ready  input  1  downstream consumes result this cycle.
- out_col  output  WIDTH  bitwise XOR of every word in the frame.
- out_row  output  1  XOR-reduce of out_col, XORed with ODD.
- out_count  output  COUNT_W  beats in the frame, saturating.
- out_sat  output  1  frame beat count reached 2^COUNT_W-1 (saturated).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: while rst is high at a clk edge, all of the following are cleared: out_valid=0, out_col=0, out_row=0, out_count=0, out_sat=0, accumulator=0, beat counter=0.
- in_ready during reset: in_ready is combinationally forced 0 while rst=1.
- Reset mid-frame: partial accumulation is discarded with no output.
- Handshake:
  - in_ready = !rst && (!out_valid || out_ready). Only one result is buffered; no input stall otherwise.
  - A beat is accepted when in_valid && in_ready. in_data/in_last are ignored otherwise. in_valid may stay high while stalled.
  - out_valid, once high, stays high with stable out_* until a cycle with out_ready=1.
- Accumulation on an accepted non-last beat: acc <= acc ^ in_data; cnt <= cnt+1, saturating at 2^COUNT_W-1.
- Accepted last beat:
  - out_col <= acc ^ in_data
  - out_row <= (^(acc ^ in_data)) ^ ODD
  - out_count <= sat(cnt+1)
  - out_sat <= (sat(cnt+1) == 2^COUNT_W-1)
  - out_valid <= 1; acc <= 0; cnt <= 0
- Latency: result visible one cycle after the last beat is accepted.
- Simultaneous consume and last:
  - If out_valid && out_ready and an accepted beat with in_last occur in the same cycle, the new result loads and out_valid stays 1. This gives back-to-back single-word frames at one result per cycle.
  - If out_ready with no new last beat, out_valid <= 0.
- Single-word frame: out_col = in_data, out_count = 1.
- Empty frames are impossible: every frame has at least one beat.
- Counter wrap: the counter never wraps. It holds at its maximum, and the XOR accumulation continues correctly.
- States: ACCUM (out_valid=0) and FULL (out_valid=1); out_valid is the state bit. Accumulation is permitted in both states whenever in_ready=1.

Test Plan:
- WIDTH=8, ODD=0, out_ready=1: frame 0x0F,0xF0,0x3C(last) -> one cycle after last: out_col=0xC3, out_row=0, out_count=3, out_valid=1 for one cycle.
- Same frame, ODD=1 -> out_col=0xC3, out_row=1.
- out_ready=0 after result, then send frame 0x01(last) -> in_ready=0, out_col stays 0xC3. Then out_ready=1 for one cycle -> 0x01 accepted that cycle, next cycle out_col=0x01, out_count=1, out_valid=1.
- Back-to-back single-word frames 0xAA,0x55,0xFF, all last, in_valid and out_ready held 1 -> out_col sequence 0xAA,0x55,0xFF on consecutive cycles, out_row 0,0,0.
- COUNT_W=2: 5-beat frame of 0x01 -> out_count=3, out_sat=1, out_col=0x01.
- rst=1 for one cycle after 2 beats of a frame, then frame 0x80(last) -> outputs all 0 during reset, then out_col=0x80, out_count=1. No stale result is emitted.

Source files
------------

// File: rtl/xor_frame_parity_if.sv
// Frame parity stream bundle: word input side plus the buffered result side.
// The source/sink drives through master; the parity block attaches as slave.
interface xor_frame_parity_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_col;
  logic               out_row;
  logic [COUNT_W-1:0] out_count;
  logic               out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_col, out_row, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_col, out_row, out_count, out_sat
  );
endinterface

// File: rtl/xor_frame_parity.sv
// Per-frame column/row parity and beat count; result registered one cycle after the last beat.
// Single result buffer: input stalls only while an unconsumed result meets out_ready=0.
module xor_frame_parity #(
  parameter int WIDTH   = 8,
  parameter int ODD     = 0,
  parameter int COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  xor_frame_parity_if.slave   io
);

  typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_e;

  typedef struct packed {
    logic [WIDTH-1:0]   col;
    logic               row;
    logic [COUNT_W-1:0] count;
    logic               sat;
  } res_t;

  localparam logic               ODD_BIT = (ODD != 0);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  res_t               res_q, res_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   acc_x;
  logic [COUNT_W-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new last beat reloads the buffer even while the old result drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && io.in_last) state_d = FULL;
      FULL: begin
        if (accept && io.in_last) state_d = FULL;
        else if (io.out_ready)    state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready     = !rst && ((state_q == ACCUM) || io.out_ready);
    io.in_ready  = in_ready;
    io.out_valid = (state_q == FULL);
    io.out_col   = res_q.col;
    io.out_row   = res_q.row;
    io.out_count = res_q.count;
    io.out_sat   = res_q.sat;
  end

  always_comb begin
    accept  = io.in_valid && in_ready;
    acc_x   = acc_q ^ io.in_data;
    // Counter holds at its maximum; the XOR accumulation keeps running.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_W'(1);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (accept) begin
      if (io.in_last) begin
        res_d.col   = acc_x;
        res_d.row   = (^acc_x) ^ ODD_BIT;
        res_d.count = cnt_inc;
        res_d.sat   = (cnt_inc == CNT_MAX);
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_x;
        cnt_d = cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Two parity blocks (even/16-bit count and odd/2-bit count) share one stimulus stream;
// a frame-level model feeds a scoreboard checked whenever a result is consumed.
module tb_xor_frame_parity;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  bit         rnd_rdy;

  int tests;
  int fails;

  typedef struct {
    logic [7:0] col;
    logic       row_a;
    logic       row_b;
    int         cnt_a;
    logic       sat_a;
    int         cnt_b;
    logic       sat_b;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  words_q[$];

  xor_frame_parity_if #(.WIDTH(8), .COUNT_W(16)) ifa ();
  xor_frame_parity_if #(.WIDTH(8), .COUNT_W(2))  ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;

  xor_frame_parity #(.WIDTH(8), .ODD(0), .COUNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .io  (ifa.slave)
  );

  xor_frame_parity #(.WIDTH(8), .ODD(1), .COUNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .io  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: a frame is the list of its words; everything derives from that list.
  function automatic exp_t frame_result(input logic [7:0] words[$]);
    exp_t e;
    int   n;
    int   ones;
    n     = words.size();
    e.col = 8'h00;
    foreach (words[i]) e.col = e.col ^ words[i];
    ones    = $countones(e.col);
    e.row_a = (ones % 2) == 1;
    e.row_b = (ones % 2) == 0;
    e.cnt_a = (n > 65535) ? 65535 : n;
    e.sat_a = (n >= 65535);
    e.cnt_b = (n > 3) ? 3 : n;
    e.sat_b = (n >= 3);
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  logic        hold_vld;
  logic [7:0]  hold_col;
  logic        hold_row;
  logic [15:0] hold_cnt;
  logic [1:0]  hold_cnt_b;

  initial hold_vld = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("in_ready_in_reset_a", {31'd0, ifa.in_ready}, 32'd0);
      chk("in_ready_in_reset_b", {31'd0, ifb.in_ready}, 32'd0);
      exp_q.delete();
      words_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_valid", {31'd0, ifa.out_valid}, 32'd1);
        chk("hold_col", {24'd0, ifa.out_col}, {24'd0, hold_col});
        chk("hold_row", {31'd0, ifa.out_row}, {31'd0, hold_row});
        chk("hold_count", {16'd0, ifa.out_count}, {16'd0, hold_cnt});
        chk("hold_count_b", {30'd0, ifb.out_count}, {30'd0, hold_cnt_b});
      end
      chk("valid_a_vs_b", {31'd0, ifb.out_valid}, {31'd0, ifa.out_valid});
      chk("in_ready_rule", {31'd0, ifa.in_ready}, {31'd0, !ifa.out_valid || out_ready});
      if (ifa.out_valid && out_ready) begin
        chk("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_col_a", {24'd0, ifa.out_col}, {24'd0, e.col});
          chk("out_col_b", {24'd0, ifb.out_col}, {24'd0, e.col});
          chk("out_row_even", {31'd0, ifa.out_row}, {31'd0, e.row_a});
          chk("out_row_odd", {31'd0, ifb.out_row}, {31'd0, e.row_b});
          chk("out_count_16", {16'd0, ifa.out_count}, 32'(e.cnt_a));
          chk("out_sat_16", {31'd0, ifa.out_sat}, {31'd0, e.sat_a});
          chk("out_count_2", {30'd0, ifb.out_count}, 32'(e.cnt_b));
          chk("out_sat_2", {31'd0, ifb.out_sat}, {31'd0, e.sat_b});
        end
      end
      hold_vld   = ifa.out_valid && !out_ready;
      hold_col   = ifa.out_col;
      hold_row   = ifa.out_row;
      hold_cnt   = ifa.out_count;
      hold_cnt_b = ifb.out_count;
      if (in_valid && ifa.in_ready) begin
        words_q.push_back(in_data);
        if (in_last) begin
          exp_q.push_back(frame_result(words_q));
          words_q.delete();
        end
      end
    end
  end

  // Holds one beat on the bus until it is accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit got;
    int n;
    got      = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!got && n < 200) begin
      @(negedge clk);
      got = ifa.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!got && rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b2b[3];
    int         len;
    b2b = '{8'hAA, 8'h55, 8'hFF};
    tests     = 0;
    fails     = 0;
    rnd_rdy   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("reset_col", {24'd0, ifa.out_col}, 32'd0);
    chk("reset_row_odd", {31'd0, ifb.out_row}, 32'd0);
    chk("reset_count", {16'd0, ifa.out_count}, 32'd0);
    chk("reset_sat_b", {31'd0, ifb.out_sat}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();

    // Basic frame, both parity modes.
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'h3C, 1'b1);
    chk("d1_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("d1_col", {24'd0, ifa.out_col}, 32'h0C3);
    chk("d1_row_even", {31'd0, ifa.out_row}, 32'd0);
    chk("d1_row_odd", {31'd0, ifb.out_row}, 32'd1);
    chk("d1_count", {16'd0, ifa.out_count}, 32'd3);
    tick();
    chk("d1_one_cycle", {31'd0, ifa.out_valid}, 32'd0);

    // Result held under backpressure while the next frame waits.
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'h3C, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_last   = 1'b1;
    repeat (3) tick();
    chk("stall_in_ready", {31'd0, ifa.in_ready}, 32'd0);
    chk("stall_col", {24'd0, ifa.out_col}, 32'h0C3);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("reload_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("reload_col", {24'd0, ifa.out_col}, 32'h001);
    chk("reload_count", {16'd0, ifa.out_count}, 32'd1);
    tick();
    out_ready = 1'b1;
    tick();

    // Back-to-back single-word frames, one result per cycle.
    for (int i = 0; i < 3; i++) begin
      send_beat(b2b[i], 1'b1);
      chk("b2b_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("b2b_col", {24'd0, ifa.out_col}, {24'd0, b2b[i]});
      chk("b2b_row", {31'd0, ifa.out_row}, 32'd0);
    end

    // Saturation in the 2-bit counter instance.
    for (int i = 0; i < 5; i++) send_beat(8'h01, i == 4);
    chk("sat_count_2", {30'd0, ifb.out_count}, 32'd3);
    chk("sat_flag_2", {31'd0, ifb.out_sat}, 32'd1);
    chk("sat_col", {24'd0, ifb.out_col}, 32'h001);
    chk("nosat_count_16", {16'd0, ifa.out_count}, 32'd5);
    chk("nosat_flag_16", {31'd0, ifa.out_sat}, 32'd0);

    // Reset mid-frame discards the partial frame.
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("midrst_col", {24'd0, ifa.out_col}, 32'd0);
    chk("midrst_count", {16'd0, ifa.out_count}, 32'd0);
    rst = 1'b0;
    send_beat(8'h80, 1'b1);
    chk("postrst_col", {24'd0, ifa.out_col}, 32'h080);
    chk("postrst_count", {16'd0, ifa.out_count}, 32'd1);
    tick();

    // Randomised frames with idle gaps and random backpressure.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 250; f++) begin
      if ($urandom_range(0, 7) == 0) len = int'($urandom_range(4, 12));
      else                           len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom);
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
        send_beat(8'($urandom), b == len - 1);
      end
    end

    rnd_rdy   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
